// File: rtl/binary_decoder.sv
// binary_decoder: N-bit index to 2^N one-hot decoder.
// Provides a combinational decode (d) and an enable-qualified registered copy
// (d_q, n_q) with a valid flag. Optional macro DECODER_ONEHOT_CHECK_EN adds a
// sticky one-hot integrity checker on the registered copy (err); without it
// err is tied low and the port list is unchanged.
module binary_decoder #(
  parameter  int N_BITS = 3,
  localparam int OUT_W  = 2**N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] n,
  input  logic              en,
  output logic [OUT_W-1:0]  d,
  output logic [OUT_W-1:0]  d_q,
  output logic [N_BITS-1:0] n_q,
  output logic              vld,
  output logic              err
);

  // Per-bit decode: each output bit is an independent equality compare.
  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    assign d[i] = (n == N_BITS'(i));
  end

  logic [OUT_W-1:0]  dq_d;
  logic [N_BITS-1:0] nq_d;
  logic              vld_d;

  // Next state: load the live decode on en, otherwise hold.
  always_comb begin
    dq_d  = d_q;
    nq_d  = n_q;
    vld_d = vld;
    if (en) begin
      dq_d  = d;
      nq_d  = n;
      vld_d = 1'b1;
    end
  end

  // Registered stage; reset clears everything but leaves d untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      n_q <= '0;
      vld <= 1'b0;
    end else begin
      d_q <= dq_d;
      n_q <= nq_d;
      vld <= vld_d;
    end
  end

`ifdef DECODER_ONEHOT_CHECK_EN
  logic [OUT_W-1:0] exp_oh;
  logic             chk_fail;
  logic             err_q;

  assign exp_oh   = OUT_W'(1) << n_q;
  assign chk_fail = vld && (!$onehot(d_q) || (d_q != exp_oh));

  // Sticky error: set one edge after a bad registered value, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (chk_fail) err_q <= 1'b1;
  end

  assign err = err_q;

`ifndef SYNTHESIS
  // Simulation-only hard stop when the registered copy is corrupted.
  always @(posedge clk) begin
    if (rst_n && chk_fail)
      $fatal(1, "binary_decoder: d_q not one-hot or inconsistent with n_q");
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_decoder.sv
// Bench for binary_decoder (N_BITS=3): table-driven combinational sweep,
// scoreboard-checked registered captures, hold/reset corner sequences.
module tb_binary_decoder;
  localparam int NB = 3;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst_n;
  logic [NB-1:0] n;
  logic          en;
  logic [OW-1:0] d, d_q;
  logic [NB-1:0] n_q;
  logic          vld, err;

  int n_chk = 0;
  int n_fail = 0;

  binary_decoder #(.N_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .n(n), .en(en),
    .d(d), .d_q(d_q), .n_q(n_q), .vld(vld), .err(err)
  );

  // Clock toggles only while clk_run is set, so the decode can be checked idle.
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [NB-1:0] n;
    logic [OW-1:0] exp_d;
  } vec_t;

  typedef struct {
    logic [OW-1:0] d;
    logic [NB-1:0] n;
  } sb_t;

  vec_t vecs[OW];
  sb_t  sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name, input logic [OW-1:0] ed, input logic [NB-1:0] en_q,
                          input logic ev);
    chk({name, ".d_q"}, 32'(d_q), 32'(ed));
    chk({name, ".n_q"}, 32'(n_q), 32'(en_q));
    chk({name, ".vld"}, 32'(vld), 32'(ev));
    chk({name, ".err"}, 32'(err), 32'd0);
  endtask

  // Drive at falling edge; on en push the expected capture, then pop and
  // compare once the DUT has taken the rising edge.
  task automatic cycle(input logic [NB-1:0] nv, input logic ev);
    sb_t e;
    @(negedge clk);
    n  = nv;
    en = ev;
    if (ev) sbq.push_back('{d: vecs[nv].exp_d, n: nv});
    @(posedge clk);
    #1;
    if (ev) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sbq.pop_front();
        chk_regs("sb", e.d, e.n, 1'b1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < OW; i++) begin
      vecs[i].n = NB'(i);
    end
    vecs[0].exp_d = 8'b0000_0001;
    vecs[1].exp_d = 8'b0000_0010;
    vecs[2].exp_d = 8'b0000_0100;
    vecs[3].exp_d = 8'b0000_1000;
    vecs[4].exp_d = 8'b0001_0000;
    vecs[5].exp_d = 8'b0010_0000;
    vecs[6].exp_d = 8'b0100_0000;
    vecs[7].exp_d = 8'b1000_0000;

    rst_n = 1'b0;
    en    = 1'b0;
    n     = '0;
    #2;
    chk_regs("reset", 8'h00, 3'd0, 1'b0);

    // Combinational sweep with the clock idle and reset held.
    foreach (vecs[i]) begin
      n = vecs[i].n;
      #1;
      chk($sformatf("comb_n%0d", i), 32'(d), 32'(vecs[i].exp_d));
    end
    rst_n = 1'b1;
    en = 1'b1;
    n = 3'd6;
    #1;
    chk("comb_no_clk_n6", 32'(d), 32'(8'h40));
    chk_regs("idle_en_no_edge", 8'h00, 3'd0, 1'b0);
    en = 1'b0;

    // Reset then release with en low: nothing captured.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    clk_run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle(NB'(c + 1), 1'b0);
      chk_regs($sformatf("post_rst_idle%0d", c), 8'h00, 3'd0, 1'b0);
    end

    // Single capture of n=5, then hold with en low while n moves to 2.
    cycle(3'd5, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(3'd2, 1'b0);
      chk_regs($sformatf("hold%0d", c), 8'h20, 3'd5, 1'b1);
      chk($sformatf("hold_d%0d", c), 32'(d), 32'(8'h04));
    end

    // Back-to-back captures, one per cycle, no bubbles.
    for (int i = 0; i < OW; i++) cycle(NB'(i), 1'b1);
    chk_regs("b2b_last", 8'h80, 3'd7, 1'b1);

    // Asynchronous reset mid-cycle: regs clear before the next edge, d still live.
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs("async_rst", 8'h00, 3'd0, 1'b0);
    n = 3'd3;
    #1;
    chk("async_rst_d", 32'(d), 32'(8'h08));
    @(posedge clk);
    #1;
    chk_regs("rst_held_edge", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First capture only on the first en edge after release.
    cycle(3'd4, 1'b0);
    chk_regs("rel_no_en", 8'h00, 3'd0, 1'b0);
    cycle(3'd1, 1'b1);
    cycle(3'd0, 1'b1);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound in case anything stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
